// File: rtl/ibus_pkg.sv
// Instruction-bus constants and state encoding shared by the prefetcher and the stream buffer.
package ibus_pkg;
  localparam int unsigned WORDS_PER_LINE = 16;
  localparam int unsigned LINE_ADDR_W    = 13;
  localparam int unsigned BYTE_ADDR_W    = 19;
  localparam int unsigned DATA_W         = 32;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_ISSUE,
    PF_DRAIN,
    PF_FLUSH
  } pf_state_e;
endpackage

// File: rtl/stream_prefetch_if.sv
// Instruction-bus word-read channel: request/grant plus in-order read responses.
interface stream_prefetch_if;
  import ibus_pkg::*;

  logic                   bus_req;
  logic [BYTE_ADDR_W-1:0] bus_addr;
  logic                   bus_gnt;
  logic                   bus_r_valid;
  logic [DATA_W-1:0]      bus_r_data;

  modport master (
    output bus_req, bus_addr,
    input  bus_gnt, bus_r_valid, bus_r_data
  );

  modport slave (
    input  bus_req, bus_addr,
    output bus_gnt, bus_r_valid, bus_r_data
  );
endinterface

// File: rtl/prefetch_credit_cnt.sv
// Outstanding-read counter; saturates at MAX_OUTSTANDING and never underflows.
module prefetch_credit_cnt #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);
  logic [2:0] count_q, count_d;
  logic       inc_ok, dec_ok;

  always_comb begin
    full    = (count_q >= 3'(MAX_OUTSTANDING));
    empty   = (count_q == '0);
    inc_ok  = inc & ~full;
    dec_ok  = dec & ~empty;
    count_d = count_q;
    unique case ({inc_ok, dec_ok})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    count = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/stream_prefetch.sv
// Cacheline prefetcher: issues one word read per grant, forwards in-order responses to the refill path.
module stream_prefetch #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WORDS_PER_LINE  = ibus_pkg::WORDS_PER_LINE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             line_req,
  input  logic [ibus_pkg::LINE_ADDR_W-1:0] line_addr,
  output logic                             line_gnt,
  input  logic                             abort,
  stream_prefetch_if.master                bus,
  output logic                             prefetch_r_valid,
  output logic [ibus_pkg::DATA_W-1:0]      prefetch_r_data,
  output logic                             busy,
  output logic                             line_done
);
  import ibus_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(WORDS_PER_LINE - 1);

  pf_state_e              state_q, state_d;
  logic [LINE_ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [3:0]             issue_cnt_q, issue_cnt_d;
  logic [3:0]             recv_cnt_q, recv_cnt_d;

  logic [2:0] outstanding, out_after;
  logic       cred_full, cred_empty;
  logic       issue_fire, resp_take, fwd;

  prefetch_credit_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (issue_fire),
    .dec   (resp_take),
    .count (outstanding),
    .full  (cred_full),
    .empty (cred_empty)
  );

  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    line_gnt     = 1'b0;
    bus.bus_req  = 1'b0;
    bus.bus_addr = {line_addr_q, issue_cnt_q, 2'b00};
    fwd          = 1'b0;
    line_done    = 1'b0;
    busy         = (state_q != PF_IDLE);
    // Responses with nothing in flight are a protocol error and are dropped here.
    resp_take    = bus.bus_r_valid & ~cred_empty & ~rst;
    out_after    = outstanding - {2'b00, resp_take};

    unique case (state_q)
      PF_IDLE: begin
        line_gnt = line_req & ~abort & ~rst;
        if (line_gnt) begin
          line_addr_d = line_addr;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = PF_ISSUE;
        end
      end
      PF_ISSUE, PF_DRAIN: begin
        bus.bus_req = (state_q == PF_ISSUE) & ~cred_full & ~abort & ~rst;
        fwd         = resp_take;
        line_done   = fwd & (state_q == PF_DRAIN) & (recv_cnt_q == LAST_IDX);
        if (bus.bus_req && bus.bus_gnt) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
          if (issue_cnt_q == LAST_IDX) state_d = PF_DRAIN;
        end
        if (fwd) recv_cnt_d = recv_cnt_q + 4'd1;
        if (line_done) state_d = PF_IDLE;
        // Abort wins over any progress made this cycle.
        if (abort) state_d = (out_after != '0) ? PF_FLUSH : PF_IDLE;
      end
      PF_FLUSH: begin
        if (out_after == '0) state_d = PF_IDLE;
      end
      default: state_d = PF_IDLE;
    endcase

    issue_fire       = bus.bus_req & bus.bus_gnt;
    prefetch_r_valid = fwd;
    prefetch_r_data  = fwd ? bus.bus_r_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PF_IDLE;
      line_addr_q <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end
endmodule

// File: tb/tb_stream_prefetch.sv
// Directed bench for stream_prefetch: full line, credit limit, grant stall, abort/flush, back-to-back lines, reset.
module tb_stream_prefetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_req = 1'b0;
  logic [12:0] line_addr = '0;
  logic        line_gnt;
  logic        abort = 1'b0;
  logic        prefetch_r_valid;
  logic [31:0] prefetch_r_data;
  logic        busy;
  logic        line_done;

  int unsigned checks = 0;
  int unsigned errors = 0;

  stream_prefetch_if bus_if ();

  stream_prefetch #(
    .MAX_OUTSTANDING(4),
    .WORDS_PER_LINE (16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .line_req         (line_req),
    .line_addr        (line_addr),
    .line_gnt         (line_gnt),
    .abort            (abort),
    .bus              (bus_if.master),
    .prefetch_r_valid (prefetch_r_valid),
    .prefetch_r_data  (prefetch_r_data),
    .busy             (busy),
    .line_done        (line_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus_if.bus_gnt     = 1'b0;
    bus_if.bus_r_valid = 1'b1;
    bus_if.bus_r_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    #1;
    chk("rst_line_gnt", 32'(line_gnt), 32'd0);
    chk("rst_bus_req",  32'(bus_if.bus_req), 32'd0);
    chk("rst_bus_addr", 32'(bus_if.bus_addr), 32'd0);
    chk("rst_pf_valid", 32'(prefetch_r_valid), 32'd0);
    chk("rst_pf_data",  prefetch_r_data, 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_done",     32'(line_done), 32'd0);

    // Line at 0x0040, always granted, responses two cycles after each grant.
    rst = 1'b0;
    bus_if.bus_r_valid = 1'b0;
    line_req  = 1'b1;
    line_addr = 13'h0040;
    #1;
    chk("l1_gnt", 32'(line_gnt), 32'd1);
    tick();
    line_req = 1'b0;
    for (int k = 0; k < 18; k++) begin
      bus_if.bus_gnt     = 1'b1;
      bus_if.bus_r_valid = (k >= 2);
      bus_if.bus_r_data  = 32'hA500_0000 + 32'(k);
      #1;
      chk("l1_bus_req", 32'(bus_if.bus_req), 32'(k < 16));
      if (k < 16) chk("l1_bus_addr", 32'(bus_if.bus_addr), 32'h1000 + 32'(4 * k));
      chk("l1_pf_valid", 32'(prefetch_r_valid), 32'(k >= 2));
      if (k >= 2) chk("l1_pf_data", prefetch_r_data, 32'hA500_0000 + 32'(k));
      chk("l1_done", 32'(line_done), 32'(k == 17));
      chk("l1_busy", 32'(busy), 32'd1);
      tick();
    end
    bus_if.bus_gnt     = 1'b0;
    bus_if.bus_r_valid = 1'b0;
    #1;
    chk("l1_busy_after", 32'(busy), 32'd0);

    // Credit limit: no responses, four grants then stall; one response reopens the window.
    line_req  = 1'b1;
    line_addr = 13'h0100;
    #1;
    chk("l2_gnt", 32'(line_gnt), 32'd1);
    tick();
    line_req = 1'b0;
    bus_if.bus_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("l2_req_open", 32'(bus_if.bus_req), 32'd1);
      chk("l2_addr", 32'(bus_if.bus_addr), 32'h4000 + 32'(4 * k));
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("l2_req_full", 32'(bus_if.bus_req), 32'd0);
      tick();
    end
    bus_if.bus_r_valid = 1'b1;
    bus_if.bus_r_data  = 32'h1234_5678;
    #1;
    chk("l2_req_release_cycle", 32'(bus_if.bus_req), 32'd0);
    chk("l2_pf_valid", 32'(prefetch_r_valid), 32'd1);
    chk("l2_pf_data", prefetch_r_data, 32'h1234_5678);
    tick();
    bus_if.bus_r_valid = 1'b0;
    #1;
    chk("l2_req_reopen", 32'(bus_if.bus_req), 32'd1);
    chk("l2_addr_w4", 32'(bus_if.bus_addr), 32'h4010);
    tick();
    #1;
    chk("l2_req_full_again", 32'(bus_if.bus_req), 32'd0);
    chk("l2_busy", 32'(busy), 32'd1);

    // Reset mid-ISSUE.
    rst = 1'b1;
    tick();
    bus_if.bus_r_valid = 1'b1;
    bus_if.bus_r_data  = 32'hFFFF_FFFF;
    #1;
    chk("mrst_bus_req",  32'(bus_if.bus_req), 32'd0);
    chk("mrst_bus_addr", 32'(bus_if.bus_addr), 32'd0);
    chk("mrst_pf_valid", 32'(prefetch_r_valid), 32'd0);
    chk("mrst_pf_data",  prefetch_r_data, 32'd0);
    chk("mrst_busy",     32'(busy), 32'd0);
    chk("mrst_done",     32'(line_done), 32'd0);
    chk("mrst_line_gnt", 32'(line_gnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("stray_resp_valid", 32'(prefetch_r_valid), 32'd0);
    chk("stray_resp_data",  prefetch_r_data, 32'd0);
    tick();
    bus_if.bus_r_valid = 1'b0;
    bus_if.bus_gnt     = 1'b0;

    // Grant stall on word 3, then abort after 6 grants / 3 responses.
    line_req  = 1'b1;
    line_addr = 13'h1ABC;
    #1;
    chk("l3_gnt", 32'(line_gnt), 32'd1);
    tick();
    line_req = 1'b0;
    for (int k = 0; k < 15; k++) begin
      logic [31:0] exp_addr;
      bus_if.bus_gnt     = (k < 3) || (k >= 8 && k <= 11);
      bus_if.bus_r_valid = (k >= 4 && k <= 6) || (k >= 12);
      bus_if.bus_r_data  = 32'hC000_0000 + 32'(k);
      abort              = (k == 11);
      if (k < 3)       exp_addr = 32'h6AF00 + 32'(4 * k);
      else if (k <= 8) exp_addr = 32'h6AF0C;
      else if (k == 9) exp_addr = 32'h6AF10;
      else             exp_addr = 32'h6AF14;
      #1;
      chk("l3_bus_req", 32'(bus_if.bus_req), 32'(k <= 10));
      if (k <= 10) chk("l3_bus_addr", 32'(bus_if.bus_addr), exp_addr);
      chk("l3_pf_valid", 32'(prefetch_r_valid), 32'(k >= 4 && k <= 6));
      if (k >= 4 && k <= 6) chk("l3_pf_data", prefetch_r_data, 32'hC000_0000 + 32'(k));
      chk("l3_done", 32'(line_done), 32'd0);
      chk("l3_busy", 32'(busy), 32'd1);
      tick();
    end
    abort              = 1'b0;
    bus_if.bus_r_valid = 1'b0;
    bus_if.bus_gnt     = 1'b0;
    #1;
    chk("l3_idle_after_flush", 32'(busy), 32'd0);

    // line_req held high across a whole line.
    line_req  = 1'b1;
    line_addr = 13'h0002;
    #1;
    chk("l4_gnt", 32'(line_gnt), 32'd1);
    tick();
    for (int k = 0; k < 18; k++) begin
      bus_if.bus_gnt     = 1'b1;
      bus_if.bus_r_valid = (k >= 2);
      bus_if.bus_r_data  = 32'h0BAD_0000 + 32'(k);
      #1;
      chk("l4_no_gnt", 32'(line_gnt), 32'd0);
      chk("l4_done", 32'(line_done), 32'(k == 17));
      tick();
    end
    bus_if.bus_gnt     = 1'b0;
    bus_if.bus_r_valid = 1'b0;
    #1;
    chk("l4_regnt", 32'(line_gnt), 32'd1);
    chk("l4_idle", 32'(busy), 32'd0);
    tick();
    line_req = 1'b0;
    #1;
    chk("l4_gnt_low", 32'(line_gnt), 32'd0);
    chk("l4_busy", 32'(busy), 32'd1);

    // Abort with nothing outstanding returns straight to IDLE.
    abort          = 1'b1;
    bus_if.bus_gnt = 1'b1;
    #1;
    chk("ab_bus_req", 32'(bus_if.bus_req), 32'd0);
    tick();
    bus_if.bus_gnt = 1'b0;
    line_req       = 1'b1;
    #1;
    chk("ab_idle", 32'(busy), 32'd0);
    chk("ab_idle_no_gnt", 32'(line_gnt), 32'd0);
    tick();
    #1;
    chk("ab_idle_stays", 32'(busy), 32'd0);
    line_req = 1'b0;
    abort    = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
